// File: rtl/rs_encoder_param_if.sv
// rs_encoder_param_if
//   Stream bundle around the Reed-Solomon encoder.
//   Input side : in_valid / in_ready / in_data (message symbols, highest degree first)
//   Output side: out_valid / out_ready / out_data plus framing flags
//                out_sop (first message symbol), out_eop (last parity symbol),
//                out_par (parity symbol).
//   slave  : the encoder's view (consumes in_*, produces out_*).
//   master : the environment's view (produces in_*, consumes out_*).
interface rs_encoder_param_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_sop;
  logic       out_eop;
  logic       out_par;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sop, out_eop, out_par
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sop, out_eop, out_par
  );
endinterface

// File: rtl/rs_encoder_param.sv
// rs_encoder_param
//   Systematic Reed-Solomon encoder over GF(2^8). K message symbols are passed
//   through unchanged, then NPAR parity symbols (remainder of m(x)*x^NPAR mod g(x))
//   are appended, highest-degree remainder coefficient first.
//   Generator g(x) = prod_{i=FCR}^{FCR+NPAR-1} (x + alpha^i), alpha = 0x02, is
//   expanded at elaboration; each tap multiply collapses to a constant XOR network.
// Ports
//   clk  : single rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : rs_encoder_param_if.slave (in_* handshake, out_* handshake + flags)
module rs_encoder_param #(
  parameter int NPAR      = 16,
  parameter int K         = 239,
  parameter int FCR       = 0,
  parameter int PRIM_POLY = 'h11D
) (
  input  logic               clk,
  input  logic               rst,
  rs_encoder_param_if.slave  bus
);

  localparam int             DATA_W  = 8;
  localparam int             CNT_MAX = (K > NPAR) ? K : NPAR;
  localparam int             CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [7:0]     POLY_LO = PRIM_POLY[7:0];

  // Shift-and-add GF(2^8) product; x^8 is folded back with the low byte of
  // the primitive polynomial.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? POLY_LO : 8'h00);
    end
    return acc;
  endfunction

  // Expand the generator polynomial one root at a time. The result holds
  // g_0..g_{NPAR-1}; the leading coefficient is implicitly 1.
  function automatic logic [DATA_W*NPAR-1:0] gen_coefs();
    logic [NPAR:0][7:0]        g;
    logic [7:0]                root;
    logic [DATA_W*NPAR-1:0]    res;
    g    = '0;
    g[0] = 8'h01;
    root = 8'h01;
    res  = '0;
    for (int i = 0; i < FCR; i++) root = gf_mul(root, 8'h02);
    for (int i = 0; i < NPAR; i++) begin
      for (int j = NPAR; j > 0; j--) g[j] = g[j-1] ^ gf_mul(g[j], root);
      g[0] = gf_mul(g[0], root);
      root = gf_mul(root, 8'h02);
    end
    for (int j = 0; j < NPAR; j++) res[DATA_W*j +: DATA_W] = g[j];
    return res;
  endfunction

  localparam logic [DATA_W*NPAR-1:0] GEN    = gen_coefs();
  localparam logic [CNT_W-1:0]       K_LAST = CNT_W'(K - 1);
  localparam logic [CNT_W-1:0]       P_LAST = CNT_W'(NPAR - 1);

  typedef enum logic {ST_MSG, ST_PAR} state_t;

  state_t                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [NPAR-1:0][DATA_W-1:0]   r_q, r_d;
  logic                          out_valid_q, out_valid_d;
  logic [DATA_W-1:0]             out_data_q, out_data_d;
  logic                          out_sop_q, out_sop_d;
  logic                          out_eop_q, out_eop_d;
  logic                          out_par_q, out_par_d;

  logic                          slot_free;
  logic                          in_ready_c;
  logic                          accept;
  logic [DATA_W-1:0]             fb;

  // Next-state / datapath
  always_comb begin
    slot_free   = !out_valid_q || bus.out_ready;
    // Held low during reset so nothing is taken while state is being cleared.
    in_ready_c  = (state_q == ST_MSG) && slot_free && !rst;
    accept      = bus.in_valid && in_ready_c;
    fb          = bus.in_data ^ r_q[NPAR-1];

    state_d     = state_q;
    cnt_d       = cnt_q;
    r_d         = r_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_par_d   = out_par_q;

    // Drained symbol frees the output register unless refilled below.
    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

    case (state_q)
      ST_MSG: begin
        if (accept) begin
          r_d[0] = gf_mul(GEN[0 +: DATA_W], fb);
          for (int i = 1; i < NPAR; i++)
            r_d[i] = r_q[i-1] ^ gf_mul(GEN[DATA_W*i +: DATA_W], fb);
          out_valid_d = 1'b1;
          out_data_d  = bus.in_data;
          out_sop_d   = (cnt_q == '0);
          out_eop_d   = 1'b0;
          out_par_d   = 1'b0;
          if (cnt_q == K_LAST) begin
            state_d = ST_PAR;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_PAR: begin
        // Shifting zeros in leaves the LFSR cleared for the next codeword.
        if (slot_free) begin
          out_valid_d = 1'b1;
          out_data_d  = r_q[NPAR-1];
          out_sop_d   = 1'b0;
          out_eop_d   = (cnt_q == P_LAST);
          out_par_d   = 1'b1;
          r_d[0]      = '0;
          for (int i = 1; i < NPAR; i++) r_d[i] = r_q[i-1];
          if (cnt_q == P_LAST) begin
            state_d = ST_MSG;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_MSG;
        cnt_d   = '0;
      end
    endcase
  end

  // State / output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_MSG;
      cnt_q       <= '0;
      r_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_par_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      r_q         <= r_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_par_q   <= out_par_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sop   = out_sop_q;
  assign bus.out_eop   = out_eop_q;
  assign bus.out_par   = out_par_q;

endmodule
